// File: rtl/config_latch_pkg.sv
// Shared constants and index helpers for the configuration latch bank.
// Geometry defaults and bit-numbering rules live here so that every file agrees on them.
package config_latch_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_WORDS  = 12;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SHIFT = 2'd2,
        OP_COLL  = 2'd3
    } op_e;

    function automatic int total_bits(input int num_words, input int data_width);
        return num_words * data_width;
    endfunction

    // Word w, bit b sits at flat position w*DATA_WIDTH + b in Q and in the scan chain.
    function automatic int flat_index(input int word, input int bit_idx, input int data_width);
        return word * data_width + bit_idx;
    endfunction

    // The counter has to hold the saturation value itself, hence the +1.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    localparam int TOTAL_BITS = total_bits(DEF_NUM_WORDS, DEF_DATA_WIDTH);

endpackage

// File: rtl/config_latch_bank_if.sv
// Bus bundle for the configuration latch bank.
// The master side drives the write, scan and readback requests; the slave side is the bank.
interface config_latch_bank_if #(
    parameter int DATA_WIDTH = config_latch_pkg::DEF_DATA_WIDTH,
    parameter int NUM_WORDS  = config_latch_pkg::DEF_NUM_WORDS,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) ();

    logic                              wr_en;
    logic [ADDR_WIDTH-1:0]             wr_addr;
    logic [DATA_WIDTH-1:0]             wr_data;
    logic [DATA_WIDTH-1:0]             wr_mask;
    logic                              sc_en;
    logic                              sc_in;
    logic                              sc_out;
    logic                              rd_en;
    logic [ADDR_WIDTH-1:0]             rd_addr;
    logic [DATA_WIDTH-1:0]             rd_data;
    logic                              rd_valid;
    logic                              prog_done;
    logic                              err_addr;
    logic                              err_coll;
    logic                              err_clr;
    logic [NUM_WORDS*DATA_WIDTH-1:0]   Q;
    logic [NUM_WORDS*DATA_WIDTH-1:0]   Qb;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mask,
        output sc_en, sc_in, rd_en, rd_addr, err_clr,
        input  sc_out, rd_data, rd_valid, prog_done,
        input  err_addr, err_coll, Q, Qb
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mask,
        input  sc_en, sc_in, rd_en, rd_addr, err_clr,
        output sc_out, rd_data, rd_valid, prog_done,
        output err_addr, err_coll, Q, Qb
    );

endinterface

// File: rtl/config_latch_word.sv
// One word line of configuration bits.
// Each bit is either masked-written or shifted one place toward the MSB, with the shift taking priority.
module config_latch_word #(
    parameter int DATA_WIDTH = config_latch_pkg::DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic [DATA_WIDTH-1:0] bit_we,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  sh_en,
    input  logic                  sc_in,
    output logic [DATA_WIDTH-1:0] row
);

    logic [DATA_WIDTH-1:0] row_reg;
    logic [DATA_WIDTH-1:0] row_next;
    logic [DATA_WIDTH-1:0] shift_src;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        if (gi == 0) begin : g_lsb
            assign shift_src[gi] = sc_in;
        end else begin : g_upper
            assign shift_src[gi] = row_reg[gi-1];
        end

        assign row_next[gi] = sh_en      ? shift_src[gi] :
                              bit_we[gi] ? wr_data[gi]   :
                                           row_reg[gi];
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            row_reg <= '0;
        end else begin
            row_reg <= row_next;
        end
    end

    assign row = row_reg;

endmodule

// File: rtl/config_latch_bank.sv
// Multi-word configuration latch bank driving a tile's Q/Qb bits.
// Owns address decode, the scan chain between rows, readback, programming tracking and error flags.
module config_latch_bank
    import config_latch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WORDS  = DEF_NUM_WORDS,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                clk,
    input  logic                resetb,
    config_latch_bank_if.slave  bus
);

    localparam int BANK_BITS = total_bits(NUM_WORDS, DATA_WIDTH);
    localparam int CNT_W     = cnt_width(BANK_BITS);

    localparam logic [ADDR_WIDTH:0] WORDS_LIM = (ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(BANK_BITS);

    op_e                    op_kind;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic                   write_ok;

    logic [DATA_WIDTH-1:0]  row_q [NUM_WORDS];
    logic [NUM_WORDS-1:0]   row_sin;
    logic [NUM_WORDS-1:0]   written_set;

    logic [NUM_WORDS-1:0]   written_reg, written_next;
    logic [CNT_W-1:0]       shift_cnt_reg, shift_cnt_next;
    logic                   prog_done_reg, prog_done_next;
    logic [DATA_WIDTH-1:0]  rd_data_reg, rd_data_next;
    logic                   rd_valid_reg;
    logic                   sc_out_reg, sc_out_next;
    logic                   err_addr_reg, err_addr_next;
    logic                   err_coll_reg, err_coll_next;
    logic [DATA_WIDTH-1:0]  rd_word;

    // A collision is a shift with the write dropped; the scan path always wins.
    always_comb begin
        op_kind = OP_IDLE;
        if (bus.sc_en && bus.wr_en) begin
            op_kind = OP_COLL;
        end else if (bus.sc_en) begin
            op_kind = OP_SHIFT;
        end else if (bus.wr_en) begin
            op_kind = OP_WRITE;
        end
    end

    assign wr_in_range = {1'b0, bus.wr_addr} < WORDS_LIM;
    assign rd_in_range = {1'b0, bus.rd_addr} < WORDS_LIM;
    assign write_ok    = (op_kind == OP_WRITE) && wr_in_range;

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_row
        logic                  row_sel;
        logic [DATA_WIDTH-1:0] bit_we;

        assign row_sel         = write_ok && (bus.wr_addr == ADDR_WIDTH'(gi));
        assign bit_we          = row_sel ? bus.wr_mask : '0;
        assign written_set[gi] = row_sel;

        // Row 0 is fed from the pin; every other row from the MSB of the row below it.
        if (gi == 0) begin : g_head
            assign row_sin[gi] = bus.sc_in;
        end else begin : g_link
            assign row_sin[gi] = row_q[gi-1][DATA_WIDTH-1];
        end

        config_latch_word #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_row (
            .clk     (clk),
            .resetb  (resetb),
            .bit_we  (bit_we),
            .wr_data (bus.wr_data),
            .sh_en   (bus.sc_en),
            .sc_in   (row_sin[gi]),
            .row     (row_q[gi])
        );

        assign bus.Q[flat_index(gi, 0, DATA_WIDTH) +: DATA_WIDTH] = row_q[gi];
    end

    assign bus.Qb = ~bus.Q;

    // Out-of-range addresses match no row and fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (bus.rd_addr == ADDR_WIDTH'(w)) begin
                rd_word = row_q[w];
            end
        end
    end

    always_comb begin
        written_next   = written_reg | written_set;
        shift_cnt_next = shift_cnt_reg;
        if (bus.sc_en && (shift_cnt_reg != CNT_MAX)) begin
            shift_cnt_next = shift_cnt_reg + CNT_W'(1);
            // A complete scan load programs every word at once.
            if (shift_cnt_next == CNT_MAX) begin
                written_next = '1;
            end
        end
        prog_done_next = prog_done_reg | (&written_next);
    end

    always_comb begin
        rd_data_next = rd_data_reg;
        if (bus.rd_en) begin
            rd_data_next = rd_word;
        end

        sc_out_next = sc_out_reg;
        if (bus.sc_en) begin
            sc_out_next = row_q[NUM_WORDS-1][DATA_WIDTH-1];
        end

        // A fresh error on the same cycle as err_clr keeps the flag set.
        err_addr_next = ((bus.wr_en && !wr_in_range) || (bus.rd_en && !rd_in_range))
                        || (err_addr_reg && !bus.err_clr);
        err_coll_next = (op_kind == OP_COLL) || (err_coll_reg && !bus.err_clr);
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            written_reg   <= '0;
            shift_cnt_reg <= '0;
            prog_done_reg <= 1'b0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            sc_out_reg    <= 1'b0;
            err_addr_reg  <= 1'b0;
            err_coll_reg  <= 1'b0;
        end else begin
            written_reg   <= written_next;
            shift_cnt_reg <= shift_cnt_next;
            prog_done_reg <= prog_done_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= bus.rd_en;
            sc_out_reg    <= sc_out_next;
            err_addr_reg  <= err_addr_next;
            err_coll_reg  <= err_coll_next;
        end
    end

    assign bus.rd_data   = rd_data_reg;
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.sc_out    = sc_out_reg;
    assign bus.prog_done = prog_done_reg;
    assign bus.err_addr  = err_addr_reg;
    assign bus.err_coll  = err_coll_reg;

endmodule

// File: tb/tb_config_latch_bank.sv
// Self-checking bench for config_latch_bank: a behavioural model tracks Q, flags and sc_out,
// and readback expectations are queued at request time and popped when rd_valid appears.
module tb_config_latch_bank;
    import config_latch_pkg::*;

    localparam int DW = 8;
    localparam int NW = 12;
    localparam int AW = $clog2(NW);
    localparam int NB = TOTAL_BITS;

    logic clk = 1'b0;
    logic resetb;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [NB-1:0] exp_q;
    logic [NW-1:0] exp_written;
    int            exp_cnt;
    logic          exp_prog;
    logic          exp_err_addr;
    logic          exp_err_coll;
    logic          exp_sc_out;
    logic [DW-1:0] rd_queue [$];

    always #5 clk = ~clk;

    config_latch_bank_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .ADDR_WIDTH(AW)) bus ();

    config_latch_bank #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    task automatic check_val(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        exp_q        = '0;
        exp_written  = '0;
        exp_cnt      = 0;
        exp_prog     = 1'b0;
        exp_err_addr = 1'b0;
        exp_err_coll = 1'b0;
        exp_sc_out   = 1'b0;
        rd_queue.delete();
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_mask = '0;
        bus.sc_en   = 1'b0;
        bus.sc_in   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.err_clr = 1'b0;
    endtask

    // Advance the model with the inputs currently driven, clock once, then compare.
    task automatic step();
        int            wa;
        int            ra;
        logic          aerr;
        logic          cerr;
        logic [DW-1:0] exp_rd;
        wa = int'(bus.wr_addr);
        ra = int'(bus.rd_addr);
        if (bus.rd_en) rd_queue.push_back(ra < NW ? exp_q[ra*DW +: DW] : 8'h00);
        aerr = (bus.wr_en && wa >= NW) || (bus.rd_en && ra >= NW);
        cerr = bus.wr_en && bus.sc_en;
        if (bus.sc_en) begin
            exp_sc_out = exp_q[NB-1];
            exp_q      = {exp_q[NB-2:0], bus.sc_in};
            if (exp_cnt < NB) begin
                exp_cnt++;
                if (exp_cnt == NB) exp_written = '1;
            end
        end else if (bus.wr_en && wa < NW) begin
            for (int b = 0; b < DW; b++) begin
                if (bus.wr_mask[b]) exp_q[wa*DW + b] = bus.wr_data[b];
            end
            exp_written[wa] = 1'b1;
        end
        exp_prog     = exp_prog | (&exp_written);
        exp_err_addr = aerr | (exp_err_addr & ~bus.err_clr);
        exp_err_coll = cerr | (exp_err_coll & ~bus.err_clr);

        $display("[TB] t=%0t wr=%0b addr=%0d data=%02h mask=%02h sc=%0b in=%0b rd=%0b raddr=%0d clr=%0b",
                 $time, bus.wr_en, wa, bus.wr_data, bus.wr_mask, bus.sc_en, bus.sc_in,
                 bus.rd_en, ra, bus.err_clr);

        @(posedge clk);
        #1;
        check_val("rd_valid", NB'(bus.rd_valid), NB'(rd_queue.size() != 0));
        if (rd_queue.size() != 0) begin
            exp_rd = rd_queue.pop_front();
            check_val("rd_data", NB'(bus.rd_data), NB'(exp_rd));
        end
        check_val("q", bus.Q, exp_q);
        check_val("qb", bus.Qb, ~exp_q);
        check_val("prog_done", NB'(bus.prog_done), NB'(exp_prog));
        check_val("err_addr", NB'(bus.err_addr), NB'(exp_err_addr));
        check_val("err_coll", NB'(bus.err_coll), NB'(exp_err_coll));
        check_val("sc_out", NB'(bus.sc_out), NB'(exp_sc_out));
    endtask

    task automatic op(input logic w, input int wa, input logic [DW-1:0] d, input logic [DW-1:0] m,
                      input logic s, input logic si, input logic r, input int ra, input logic c);
        bus.wr_en   = w;
        bus.wr_addr = AW'(wa);
        bus.wr_data = d;
        bus.wr_mask = m;
        bus.sc_en   = s;
        bus.sc_in   = si;
        bus.rd_en   = r;
        bus.rd_addr = AW'(ra);
        bus.err_clr = c;
        step();
    endtask

    // Called just after an edge: reset lands between edges and is checked before any clock.
    task automatic do_reset(input string tag);
        #2;
        resetb = 1'b1;
        #1;
        check_val({tag, "_q"},         bus.Q,                  '0);
        check_val({tag, "_qb"},        bus.Qb,                 '1);
        check_val({tag, "_sc_out"},    NB'(bus.sc_out),        '0);
        check_val({tag, "_prog_done"}, NB'(bus.prog_done),     '0);
        check_val({tag, "_errors"},    NB'({bus.err_addr, bus.err_coll}), '0);
        idle_inputs();
        clear_model();
        @(posedge clk);
        #1;
        resetb = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] scan_pat;

        resetb = 1'b1;
        idle_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_q",        bus.Q,               '0);
        check_val("reset_qb",       bus.Qb,              '1);
        check_val("reset_rd",       NB'({bus.rd_data, bus.rd_valid}), '0);
        check_val("reset_sc_out",   NB'(bus.sc_out),     '0);
        check_val("reset_prog",     NB'(bus.prog_done),  '0);
        check_val("reset_errs",     NB'({bus.err_addr, bus.err_coll}), '0);
        resetb = 1'b0;

        // Masked writes to word 3
        op(1, 3, 8'hA5, 8'hFF, 0, 0, 0, 0, 0);
        op(1, 3, 8'hFF, 8'h0F, 0, 0, 0, 0, 0);
        check_val("masked_q_w3",  NB'(bus.Q[3*DW +: DW]),  NB'(8'hAF));
        check_val("masked_qb_w3", NB'(bus.Qb[3*DW +: DW]), NB'(8'h50));

        // Read-before-write on word 5
        op(1, 5, 8'h3C, 8'hFF, 0, 0, 1, 5, 0);
        check_val("hazard_old", NB'({bus.rd_valid, bus.rd_data}), NB'(9'h100));
        op(0, 0, 8'h00, 8'h00, 0, 0, 1, 5, 0);
        check_val("hazard_new", NB'(bus.rd_data), NB'(8'h3C));

        // Out-of-range write, collision, clear, clear racing a new error, out-of-range read
        op(1, 12, 8'hFF, 8'hFF, 0, 0, 0, 0, 0);
        check_val("oob_wr_err", NB'(bus.err_addr), NB'(1'b1));
        op(1, 0, 8'hFF, 8'hFF, 1, 1, 0, 0, 0);
        check_val("coll_err", NB'(bus.err_coll), NB'(1'b1));
        check_val("coll_w0",  NB'(bus.Q[DW-1:0]), NB'(8'h01));
        op(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        check_val("clr_errs", NB'({bus.err_addr, bus.err_coll}), '0);
        op(0, 0, 8'h00, 8'h00, 0, 0, 1, 13, 1);
        check_val("clr_race_err", NB'(bus.err_addr), NB'(1'b1));
        check_val("oob_rd", NB'({bus.rd_valid, bus.rd_data}), NB'(9'h100));
        op(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);

        // Partial then complete word programming
        do_reset("rst_a");
        for (int w = 0; w < NW - 1; w++) begin
            op(1, w, DW'(w * 17 + 1), 8'hFF, 0, 0, 0, 0, 0);
        end
        check_val("partial_prog", NB'(bus.prog_done), '0);
        op(1, NW - 1, 8'h77, 8'h00, 0, 0, 0, 0, 0);
        check_val("full_prog", NB'(bus.prog_done), NB'(1'b1));
        op(0, 0, 8'h00, 8'h00, 0, 0, 1, NW - 1, 0);

        // Full scan load: a single 1 followed by zeros
        do_reset("rst_b");
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) check_val("scan_prog_before", NB'(bus.prog_done), '0);
            op(0, 0, 8'h00, 8'h00, 1, (i == 0), 0, 0, 0);
        end
        scan_pat = '0;
        scan_pat[NB-1] = 1'b1;
        check_val("scan_q", bus.Q, scan_pat);
        check_val("scan_prog", NB'(bus.prog_done), NB'(1'b1));
        op(0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0);
        check_val("scan_unload", NB'(bus.sc_out), NB'(1'b1));

        // Reset asserted mid-scan while sc_en is still high
        do_reset("rst_mid");

        op(1, 7, 8'h5A, 8'hFF, 0, 0, 1, 7, 0);
        op(0, 0, 8'h00, 8'h00, 0, 0, 1, 7, 0);
        check_val("post_reset_rd", NB'(bus.rd_data), NB'(8'h5A));
        op(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
